// File: rtl/control_pkg.sv
// Shared encodings for the CPU control unit: FSM states, opcode classes and
// datapath mux-select constants.
package control_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    CL_RALU,
    CL_IALU,
    CL_LW,
    CL_SW,
    CL_NOP,
    CL_BR,
    CL_SHIFT,
    CL_JMP,
    CL_JSR,
    CL_RET,
    CL_HALT
  } class_e;

  localparam logic [4:0] OP_LW   = 5'b10000;
  localparam logic [4:0] OP_SW   = 5'b10001;
  localparam logic [4:0] OP_JMP  = 5'b11100;
  localparam logic [4:0] OP_JSR  = 5'b11101;
  localparam logic [4:0] OP_RET  = 5'b11110;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [1:0] PCSEL_INC   = 2'b00;
  localparam logic [1:0] PCSEL_IMM   = 2'b01;
  localparam logic [1:0] PCSEL_STACK = 2'b10;

  localparam logic [1:0] WDSEL_ALU   = 2'b00;
  localparam logic [1:0] WDSEL_SHIFT = 2'b01;
  localparam logic [1:0] WDSEL_MEM   = 2'b10;

  function automatic class_e decode_class(input logic [4:0] op);
    class_e c;
    c = CL_NOP;
    casez (op)
      5'b00???: c = CL_RALU;
      5'b01???: c = CL_IALU;
      OP_LW:    c = CL_LW;
      OP_SW:    c = CL_SW;
      5'b1001?: c = CL_NOP;
      5'b101??: c = CL_BR;
      5'b110??: c = CL_SHIFT;
      OP_JMP:   c = CL_JMP;
      OP_JSR:   c = CL_JSR;
      OP_RET:   c = CL_RET;
      OP_HALT:  c = CL_HALT;
      default:  c = CL_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/return_stack.sv
// Return-address stack for JSR/RET. Saturating: a push when full or a pop
// when empty is ignored here and reported to the controller through full/empty.
module return_stack #(
  parameter int STACK_DEPTH = 8,
  parameter int PC_W        = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] data_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [PC_W-1:0] top_o
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(STACK_DEPTH);

  logic [PC_W-1:0] mem_q [STACK_DEPTH];
  logic [AW:0]     sp_q, sp_d;
  logic [AW-1:0]   top_idx;

  assign full_o  = (sp_q == FULL_CNT);
  assign empty_o = (sp_q == '0);
  assign top_idx = sp_q[AW-1:0] - AW'(1);
  assign top_o   = empty_o ? '0 : mem_q[top_idx];

  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o) begin
      sp_d = sp_q + (AW+1)'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entries need no reset: the pointer alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[sp_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle controller for the 8-bit CPU: FSM plus instruction decode that
// drives all datapath controls, with PC redirect via a return-address stack.
//
//   state | meaning
//   FETCH | latch IR, PC <= PC+1
//   EXEC  | execute / redirect PC / update flags
//   MEM   | data-memory access for LW/SW
//   WB    | register-file write
//   HALT  | stopped until reset
module control_unit
  import control_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter int PC_W        = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [18:0]     instruction,
  input  logic            COutput,
  input  logic            ZOutput,
  input  logic [PC_W-1:0] pcIn,
  output logic            irEn,
  output logic            pcEn,
  output logic [1:0]      pcSel,
  output logic [PC_W-1:0] stackTop,
  output logic            CEn,
  output logic            ZEn,
  output logic            regWrite,
  output logic            regFileReadRegister2Select,
  output logic            ALUBInputSelect,
  output logic [2:0]      ALUOperation,
  output logic [1:0]      regFileWriteDataSelect,
  output logic [1:0]      SHROOperation,
  output logic            DMMemWrite,
  output logic            DMMemRead,
  output logic            halted,
  output logic            stackErr
);

  state_e state_q, state_d;
  logic   err_q, err_d;
  class_e cls;
  logic   br_taken;
  logic   push, pop, st_full, st_empty;
  logic   unused_instr;

  assign cls          = decode_class(instruction[18:14]);
  assign unused_instr = ^instruction[13:0];
  assign halted       = (state_q == ST_HALT);
  assign stackErr     = err_q;

  assign br_taken = (instruction[15:14] == 2'b00) ?  ZOutput :
                    (instruction[15:14] == 2'b01) ? !ZOutput :
                    (instruction[15:14] == 2'b10) ?  COutput : !COutput;

  return_stack #(
    .STACK_DEPTH(STACK_DEPTH),
    .PC_W       (PC_W)
  ) u_stack (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .data_i (pcIn),
    .full_o (st_full),
    .empty_o(st_empty),
    .top_o  (stackTop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d                    = state_q;
    err_d                      = err_q;
    push                       = 1'b0;
    pop                        = 1'b0;
    irEn                       = 1'b0;
    pcEn                       = 1'b0;
    pcSel                      = PCSEL_INC;
    CEn                        = 1'b0;
    ZEn                        = 1'b0;
    regWrite                   = 1'b0;
    DMMemWrite                 = 1'b0;
    DMMemRead                  = 1'b0;
    ALUBInputSelect            = 1'b0;
    regFileReadRegister2Select = 1'b0;
    ALUOperation               = 3'b000;
    regFileWriteDataSelect     = WDSEL_ALU;
    SHROOperation              = 2'b00;

    // Datapath selects stay stable for the whole EXEC..WB window.
    if (state_q inside {ST_EXEC, ST_MEM, ST_WB}) begin
      case (cls)
        CL_RALU: begin
          ALUBInputSelect            = 1'b1;
          regFileReadRegister2Select = 1'b1;
          ALUOperation               = instruction[16:14];
        end
        CL_IALU:  ALUOperation = instruction[16:14];
        CL_LW:    regFileWriteDataSelect = WDSEL_MEM;
        CL_SHIFT: begin
          regFileWriteDataSelect = WDSEL_SHIFT;
          SHROOperation          = instruction[15:14];
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_FETCH: begin
        // Held low during reset so the first fetch starts on release.
        irEn    = ~rst;
        pcEn    = ~rst;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (cls)
          CL_RALU, CL_IALU: begin
            CEn     = 1'b1;
            ZEn     = 1'b1;
            state_d = ST_WB;
          end
          CL_SHIFT:     state_d = ST_WB;
          CL_LW, CL_SW: state_d = ST_MEM;
          CL_BR: begin
            pcSel = PCSEL_IMM;
            pcEn  = br_taken;
          end
          CL_JMP: begin
            pcSel = PCSEL_IMM;
            pcEn  = 1'b1;
          end
          CL_JSR: begin
            if (st_full) begin
              err_d   = 1'b1;
              state_d = ST_HALT;
            end else begin
              pcSel = PCSEL_IMM;
              pcEn  = 1'b1;
              push  = 1'b1;
            end
          end
          CL_RET: begin
            if (st_empty) begin
              err_d   = 1'b1;
              state_d = ST_HALT;
            end else begin
              pcSel = PCSEL_STACK;
              pcEn  = 1'b1;
              pop   = 1'b1;
            end
          end
          CL_HALT: state_d = ST_HALT;
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        state_d = ST_FETCH;
        if (cls == CL_LW) begin
          DMMemRead = 1'b1;
          state_d   = ST_WB;
        end else if (cls == CL_SW) begin
          DMMemWrite = 1'b1;
        end
      end
      ST_WB: begin
        regWrite  = 1'b1;
        DMMemRead = (cls == CL_LW);
        state_d   = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: per-scenario tasks with
// hand-computed expected control vectors.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [18:0] instruction = '0;
  logic        COutput = 1'b0;
  logic        ZOutput = 1'b0;
  logic [11:0] pcIn = '0;
  logic        irEn, pcEn, CEn, ZEn, regWrite, regFileReadRegister2Select;
  logic        ALUBInputSelect, DMMemWrite, DMMemRead, halted, stackErr;
  logic [1:0]  pcSel, regFileWriteDataSelect, SHROOperation;
  logic [2:0]  ALUOperation;
  logic [11:0] stackTop;

  int total = 0;
  int bad   = 0;

  control_unit #(.STACK_DEPTH(8), .PC_W(12)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .COutput(COutput), .ZOutput(ZOutput),
    .pcIn(pcIn), .irEn(irEn), .pcEn(pcEn), .pcSel(pcSel), .stackTop(stackTop), .CEn(CEn), .ZEn(ZEn),
    .regWrite(regWrite), .regFileReadRegister2Select(regFileReadRegister2Select),
    .ALUBInputSelect(ALUBInputSelect), .ALUOperation(ALUOperation),
    .regFileWriteDataSelect(regFileWriteDataSelect), .SHROOperation(SHROOperation),
    .DMMemWrite(DMMemWrite), .DMMemRead(DMMemRead), .halted(halted), .stackErr(stackErr)
  );

  always #5 clk = ~clk;

  // {irEn, pcEn, pcSel[1:0], CEn, ZEn, regWrite, DMMemWrite, DMMemRead, halted}
  logic [9:0] strobes;
  // {ALUBInputSelect, regFileReadRegister2Select, regFileWriteDataSelect[1:0], ALUOperation[2:0], SHROOperation[1:0]}
  logic [8:0] sels;
  assign strobes = {irEn, pcEn, pcSel, CEn, ZEn, regWrite, DMMemWrite, DMMemRead, halted};
  assign sels    = {ALUBInputSelect, regFileReadRegister2Select, regFileWriteDataSelect, ALUOperation, SHROOperation};

  localparam logic [9:0] S_IDLE  = 10'b0000000000;
  localparam logic [9:0] S_FETCH = 10'b1100000000;
  localparam logic [9:0] S_FLAGS = 10'b0000110000;
  localparam logic [9:0] S_WR    = 10'b0000001000;
  localparam logic [9:0] S_MW    = 10'b0000000100;
  localparam logic [9:0] S_MR    = 10'b0000000010;
  localparam logic [9:0] S_WR_MR = 10'b0000001010;
  localparam logic [9:0] S_BR    = 10'b0101000000;
  localparam logic [9:0] S_RET   = 10'b0110000000;
  localparam logic [9:0] S_HALT  = 10'b0000000001;

  task automatic do_reset();
    rst = 1'b1;
    instruction = 19'h48000;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instruction = '0;
    #3;
    total++; if (strobes !== S_IDLE) begin bad++; $display("FAIL reset_strobes got=%b exp=%b", strobes, S_IDLE); end
    total++; if ({stackErr, stackTop} !== 13'h0) begin bad++; $display("FAIL reset_stack got=%h exp=0", {stackErr, stackTop}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (strobes !== S_FETCH) begin bad++; $display("FAIL reset_release_fetch got=%b exp=%b", strobes, S_FETCH); end
    total++; if (sels !== 9'h0) begin bad++; $display("FAIL fetch_sels got=%b exp=0", sels); end
  endtask

  task automatic test_r_alu();
    instruction = 19'h00C20;
    @(negedge clk);
    total++; if (strobes !== S_FLAGS) begin bad++; $display("FAIL ralu0_exec got=%b exp=%b", strobes, S_FLAGS); end
    total++; if (sels !== 9'b110000000) begin bad++; $display("FAIL ralu0_exec_sels got=%b exp=%b", sels, 9'b110000000); end
    @(negedge clk);
    total++; if (strobes !== S_WR) begin bad++; $display("FAIL ralu0_wb got=%b exp=%b", strobes, S_WR); end
    @(negedge clk);
    total++; if (strobes !== S_FETCH) begin bad++; $display("FAIL ralu0_fetch got=%b exp=%b", strobes, S_FETCH); end
    instruction = 19'h0CC20;
    @(negedge clk);
    total++; if (sels !== 9'b110001100) begin bad++; $display("FAIL ralu3_exec_sels got=%b exp=%b", sels, 9'b110001100); end
    @(negedge clk);
    total++; if (sels !== 9'b110001100) begin bad++; $display("FAIL ralu3_wb_sels got=%b exp=%b", sels, 9'b110001100); end
    @(negedge clk);
  endtask

  task automatic test_i_alu();
    instruction = 19'h34012;
    @(negedge clk);
    total++; if (strobes !== S_FLAGS) begin bad++; $display("FAIL ialu_exec got=%b exp=%b", strobes, S_FLAGS); end
    total++; if (sels !== 9'b000010100) begin bad++; $display("FAIL ialu_sels got=%b exp=%b", sels, 9'b000010100); end
    @(negedge clk);
    total++; if (strobes !== S_WR) begin bad++; $display("FAIL ialu_wb got=%b exp=%b", strobes, S_WR); end
    @(negedge clk);
  endtask

  task automatic test_load_store();
    instruction = 19'h40105;
    @(negedge clk);
    total++; if (strobes !== S_IDLE) begin bad++; $display("FAIL lw_exec got=%b exp=%b", strobes, S_IDLE); end
    total++; if (sels !== 9'b001000000) begin bad++; $display("FAIL lw_exec_sels got=%b exp=%b", sels, 9'b001000000); end
    @(negedge clk);
    total++; if (strobes !== S_MR) begin bad++; $display("FAIL lw_mem got=%b exp=%b", strobes, S_MR); end
    @(negedge clk);
    total++; if (strobes !== S_WR_MR) begin bad++; $display("FAIL lw_wb got=%b exp=%b", strobes, S_WR_MR); end
    total++; if (regFileWriteDataSelect !== 2'b10) begin bad++; $display("FAIL lw_wb_sel got=%b exp=10", regFileWriteDataSelect); end
    @(negedge clk);
    total++; if (strobes !== S_FETCH) begin bad++; $display("FAIL lw_fetch got=%b exp=%b", strobes, S_FETCH); end
    instruction = 19'h44105;
    @(negedge clk);
    total++; if (sels !== 9'h0) begin bad++; $display("FAIL sw_exec_sels got=%b exp=0", sels); end
    @(negedge clk);
    total++; if (strobes !== S_MW) begin bad++; $display("FAIL sw_mem got=%b exp=%b", strobes, S_MW); end
    @(negedge clk);
    total++; if (strobes !== S_FETCH) begin bad++; $display("FAIL sw_fetch got=%b exp=%b", strobes, S_FETCH); end
  endtask

  task automatic test_shift_nop();
    instruction = 19'h68000;
    @(negedge clk);
    total++; if (strobes !== S_IDLE) begin bad++; $display("FAIL shift_exec got=%b exp=%b", strobes, S_IDLE); end
    total++; if (sels !== 9'b000100010) begin bad++; $display("FAIL shift_sels got=%b exp=%b", sels, 9'b000100010); end
    @(negedge clk);
    total++; if (strobes !== S_WR) begin bad++; $display("FAIL shift_wb got=%b exp=%b", strobes, S_WR); end
    @(negedge clk);
    instruction = 19'h48000;
    @(negedge clk);
    total++; if ({strobes, sels} !== 19'h0) begin bad++; $display("FAIL nop_exec got=%h exp=0", {strobes, sels}); end
    @(negedge clk);
    total++; if (strobes !== S_FETCH) begin bad++; $display("FAIL nop_fetch got=%b exp=%b", strobes, S_FETCH); end
  endtask

  task automatic test_branch();
    instruction = 19'h500A5;
    ZOutput = 1'b1;
    @(negedge clk);
    total++; if (strobes !== S_BR) begin bad++; $display("FAIL bz_taken got=%b exp=%b", strobes, S_BR); end
    ZOutput = 1'b0;
    #1;
    total++; if (pcEn !== 1'b0) begin bad++; $display("FAIL bz_comb_flag got=%b exp=0", pcEn); end
    @(negedge clk);
    total++; if (strobes !== S_FETCH) begin bad++; $display("FAIL bz_fetch got=%b exp=%b", strobes, S_FETCH); end
    @(negedge clk);
    total++; if (pcEn !== 1'b0) begin bad++; $display("FAIL bz_not_taken got=%b exp=0", pcEn); end
    @(negedge clk);
    total++; if (strobes !== S_FETCH) begin bad++; $display("FAIL bz_nt_fetch got=%b exp=%b", strobes, S_FETCH); end
    instruction = 19'h5C000;
    COutput = 1'b0;
    @(negedge clk);
    total++; if (strobes !== S_BR) begin bad++; $display("FAIL bnc_taken got=%b exp=%b", strobes, S_BR); end
    @(negedge clk);
    instruction = 19'h58000;
    @(negedge clk);
    total++; if (pcEn !== 1'b0) begin bad++; $display("FAIL bc_not_taken got=%b exp=0", pcEn); end
    @(negedge clk);
    instruction = 19'h70123;
    @(negedge clk);
    total++; if (strobes !== S_BR) begin bad++; $display("FAIL jmp_exec got=%b exp=%b", strobes, S_BR); end
    @(negedge clk);
  endtask

  task automatic test_call_return();
    do_reset();
    pcIn = 12'h011;
    instruction = 19'h74000;
    @(negedge clk);
    total++; if (strobes !== S_BR) begin bad++; $display("FAIL jsr_exec got=%b exp=%b", strobes, S_BR); end
    @(negedge clk);
    total++; if (stackTop !== 12'h011) begin bad++; $display("FAIL jsr_top got=%h exp=011", stackTop); end
    pcIn = 12'h0A6;
    instruction = 19'h78000;
    @(negedge clk);
    total++; if (strobes !== S_RET) begin bad++; $display("FAIL ret_exec got=%b exp=%b", strobes, S_RET); end
    total++; if (stackTop !== 12'h011) begin bad++; $display("FAIL ret_top got=%h exp=011", stackTop); end
    @(negedge clk);
    total++; if (stackTop !== 12'h000) begin bad++; $display("FAIL ret_empty_top got=%h exp=000", stackTop); end
    @(negedge clk);
    total++; if (strobes !== S_IDLE) begin bad++; $display("FAIL underflow_exec got=%b exp=%b", strobes, S_IDLE); end
    @(negedge clk);
    total++; if ({strobes, stackErr} !== {S_HALT, 1'b1}) begin bad++; $display("FAIL underflow_halt got=%b exp=%b", {strobes, stackErr}, {S_HALT, 1'b1}); end
  endtask

  task automatic test_overflow();
    do_reset();
    instruction = 19'h74000;
    for (int i = 0; i < 8; i++) begin
      pcIn = 12'h100 + 12'(i);
      @(negedge clk);
      @(negedge clk);
    end
    total++; if (stackTop !== 12'h107) begin bad++; $display("FAIL nest8_top got=%h exp=107", stackTop); end
    total++; if (stackErr !== 1'b0) begin bad++; $display("FAIL nest8_err got=%b exp=0", stackErr); end
    pcIn = 12'h1FF;
    @(negedge clk);
    total++; if (strobes !== S_IDLE) begin bad++; $display("FAIL overflow_exec got=%b exp=%b", strobes, S_IDLE); end
    @(negedge clk);
    total++; if ({strobes, stackErr} !== {S_HALT, 1'b1}) begin bad++; $display("FAIL overflow_halt got=%b exp=%b", {strobes, stackErr}, {S_HALT, 1'b1}); end
    total++; if (stackTop !== 12'h107) begin bad++; $display("FAIL overflow_top got=%h exp=107", stackTop); end
  endtask

  task automatic test_halt();
    do_reset();
    instruction = 19'h7C000;
    @(negedge clk);
    total++; if (strobes !== S_IDLE) begin bad++; $display("FAIL halt_exec got=%b exp=%b", strobes, S_IDLE); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++; if (strobes !== S_HALT) begin bad++; $display("FAIL halt_hold cyc=%0d got=%b exp=%b", i, strobes, S_HALT); end
    end
    rst = 1'b1;
    #2;
    total++; if (strobes !== S_IDLE) begin bad++; $display("FAIL halt_rst got=%b exp=%b", strobes, S_IDLE); end
    instruction = 19'h48000;
    rst = 1'b0;
    #1;
    total++; if (strobes !== S_FETCH) begin bad++; $display("FAIL halt_release got=%b exp=%b", strobes, S_FETCH); end
  endtask

  task automatic test_reset_mid_wb();
    do_reset();
    pcIn = 12'h022;
    instruction = 19'h74000;
    @(negedge clk);
    @(negedge clk);
    total++; if (stackTop !== 12'h022) begin bad++; $display("FAIL midwb_push got=%h exp=022", stackTop); end
    instruction = 19'h40105;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    total++; if (strobes !== S_WR_MR) begin bad++; $display("FAIL midwb_wb got=%b exp=%b", strobes, S_WR_MR); end
    #2;
    rst = 1'b1;
    #1;
    total++; if ({regWrite, DMMemRead} !== 2'b00) begin bad++; $display("FAIL midwb_async got=%b exp=00", {regWrite, DMMemRead}); end
    total++; if ({stackTop, stackErr, strobes} !== 23'h0) begin bad++; $display("FAIL midwb_cleared got=%h exp=0", {stackTop, stackErr, strobes}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (strobes !== S_FETCH) begin bad++; $display("FAIL midwb_release got=%b exp=%b", strobes, S_FETCH); end
  endtask

  initial begin
    test_reset();
    test_r_alu();
    test_i_alu();
    test_load_store();
    test_shift_nop();
    test_branch();
    test_call_return();
    test_overflow();
    test_halt();
    test_reset_mid_wb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
